// File: rtl/pipe_scheduler_if.sv
// Control and pipe-state bundle between the game-tick/core side and the pipe scheduler.
interface pipe_scheduler_if;
  logic       tick;
  logic       run;
  logic       hit;
  logic       clear;
  logic [9:0] pipe1_x;
  logic [9:0] pipe1_gap;
  logic       pipe1_valid;
  logic [9:0] pipe2_x;
  logic [9:0] pipe2_gap;
  logic       pipe2_valid;
  logic [7:0] score;
  logic       score_pulse;
  logic [1:0] state;

  modport master (
    output tick, run, hit, clear,
    input  pipe1_x, pipe1_gap, pipe1_valid,
    input  pipe2_x, pipe2_gap, pipe2_valid,
    input  score, score_pulse, state
  );

  modport slave (
    input  tick, run, hit, clear,
    output pipe1_x, pipe1_gap, pipe1_valid,
    output pipe2_x, pipe2_gap, pipe2_valid,
    output score, score_pulse, state
  );
endinterface

// File: rtl/pipe_scheduler.sv
// Owns both pipe slots: spawn, scroll, recycle with LFSR gaps, and scoring at the bird column.
module pipe_scheduler #(
  parameter int unsigned SCREEN_WIDTH = 640,
  parameter int unsigned PIPE_WIDTH   = 40,
  parameter int unsigned PIPE_SPACING = 320,
  parameter int unsigned SCROLL_STEP  = 1,
  parameter int unsigned BIRD_X       = 320,
  parameter int unsigned GAP_MIN      = 40,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  pipe_scheduler_if.slave  bus
);

  localparam logic [9:0]  SPAWN_X  = 10'(SCREEN_WIDTH);
  localparam logic [9:0]  SPAWN2_X = 10'(SCREEN_WIDTH - PIPE_SPACING);
  localparam logic [9:0]  STEP_X   = 10'(SCROLL_STEP);
  localparam logic [9:0]  GAP_BASE = 10'(GAP_MIN);
  localparam logic [10:0] WIDTH_W  = 11'(PIPE_WIDTH);
  localparam logic [10:0] BIRD_W   = 11'(BIRD_X);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCROLL = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [9:0] gap_of(input logic [7:0] v);
    gap_of = GAP_BASE + {2'b00, v};
  endfunction

  // Trailing edge crosses the bird column on this step (11-bit sums avoid overflow).
  function automatic logic passes(input logic [9:0] old_x, input logic [9:0] new_x);
    passes = (({1'b0, old_x} + WIDTH_W) > BIRD_W) && (({1'b0, new_x} + WIDTH_W) <= BIRD_W);
  endfunction

  state_t      state_r, state_nxt_s;
  logic [15:0] lfsr_r, lfsr_nxt_s;
  logic [9:0]  pipe1_x_r, pipe1_gap_r, pipe2_x_r, pipe2_gap_r;
  logic        pipe1_valid_r, pipe2_valid_r;
  logic [7:0]  score_r;
  logic        score_pulse_r;

  logic [9:0]  pipe1_x_nxt_s, pipe1_gap_nxt_s, pipe2_x_nxt_s, pipe2_gap_nxt_s;
  logic        pipe1_valid_nxt_s, pipe2_valid_nxt_s;
  logic [7:0]  score_nxt_s;
  logic        score_pulse_nxt_s;

  logic        p1_wrap_s, p2_wrap_s, p1_pass_s, p2_pass_s;
  logic [9:0]  p1_step_x_s, p2_step_x_s, p2_gap_new_s;
  logic [1:0]  inc_s;
  logic [8:0]  score_sum_s;

  assign lfsr_nxt_s = lfsr_step(lfsr_r);

  // Gap LFSR free-runs every clock; only the hard reset reseeds it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_nxt_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic: clear > hit > run.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.clear) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:   state_nxt_s = bus.run ? ST_SCROLL : ST_IDLE;
        ST_SCROLL: state_nxt_s = bus.hit ? ST_FROZEN : ST_SCROLL;
        ST_FROZEN: state_nxt_s = ST_FROZEN;
        default:   state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Per-pipe step candidates, independent of whether this cycle actually scrolls.
  always_comb begin
    p1_wrap_s    = pipe1_x_r < STEP_X;
    p2_wrap_s    = pipe2_x_r < STEP_X;
    p1_step_x_s  = p1_wrap_s ? SPAWN_X : (pipe1_x_r - STEP_X);
    p2_step_x_s  = p2_wrap_s ? SPAWN_X : (pipe2_x_r - STEP_X);
    // pipe2 draws one LFSR step later whenever pipe1 also draws a gap this tick.
    p2_gap_new_s = p1_wrap_s ? gap_of(lfsr_nxt_s[7:0]) : gap_of(lfsr_r[7:0]);
    p1_pass_s    = pipe1_valid_r && !p1_wrap_s && passes(pipe1_x_r, p1_step_x_s);
    p2_pass_s    = pipe2_valid_r && !p2_wrap_s && passes(pipe2_x_r, p2_step_x_s);
    inc_s        = {1'b0, p1_pass_s} + {1'b0, p2_pass_s};
    score_sum_s  = {1'b0, score_r} + {7'b0000000, inc_s};
  end

  // FSM output logic: next values of the registered pipe/score outputs.
  always_comb begin
    pipe1_x_nxt_s     = pipe1_x_r;
    pipe1_gap_nxt_s   = pipe1_gap_r;
    pipe1_valid_nxt_s = pipe1_valid_r;
    pipe2_x_nxt_s     = pipe2_x_r;
    pipe2_gap_nxt_s   = pipe2_gap_r;
    pipe2_valid_nxt_s = pipe2_valid_r;
    score_nxt_s       = score_r;
    score_pulse_nxt_s = 1'b0;
    if (bus.clear) begin
      pipe1_x_nxt_s     = SPAWN_X;
      pipe1_gap_nxt_s   = GAP_BASE;
      pipe1_valid_nxt_s = 1'b0;
      pipe2_x_nxt_s     = SPAWN_X;
      pipe2_gap_nxt_s   = GAP_BASE;
      pipe2_valid_nxt_s = 1'b0;
      score_nxt_s       = 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.run) begin
            pipe1_valid_nxt_s = 1'b1;
            pipe1_x_nxt_s     = SPAWN_X;
            pipe1_gap_nxt_s   = gap_of(lfsr_r[7:0]);
          end else begin
            pipe1_valid_nxt_s = pipe1_valid_r;
          end
        end
        ST_SCROLL: begin
          if (bus.hit) begin
            score_pulse_nxt_s = 1'b0;
          end else if (bus.tick) begin
            if (pipe1_valid_r) begin
              pipe1_x_nxt_s = p1_step_x_s;
              if (p1_wrap_s) begin
                pipe1_gap_nxt_s = gap_of(lfsr_r[7:0]);
              end else begin
                pipe1_gap_nxt_s = pipe1_gap_r;
              end
            end else begin
              pipe1_x_nxt_s = pipe1_x_r;
            end
            if (pipe2_valid_r) begin
              pipe2_x_nxt_s = p2_step_x_s;
              if (p2_wrap_s) begin
                pipe2_gap_nxt_s = p2_gap_new_s;
              end else begin
                pipe2_gap_nxt_s = pipe2_gap_r;
              end
            end else if (pipe1_valid_r && !p1_wrap_s && (p1_step_x_s == SPAWN2_X)) begin
              pipe2_valid_nxt_s = 1'b1;
              pipe2_x_nxt_s     = SPAWN_X;
              pipe2_gap_nxt_s   = p2_gap_new_s;
            end else begin
              pipe2_valid_nxt_s = 1'b0;
            end
            if ((inc_s != 2'd0) && (score_r != 8'hFF)) begin
              score_nxt_s       = score_sum_s[8] ? 8'hFF : score_sum_s[7:0];
              score_pulse_nxt_s = 1'b1;
            end else begin
              score_nxt_s = score_r;
            end
          end else begin
            score_pulse_nxt_s = 1'b0;
          end
        end
        ST_FROZEN: score_pulse_nxt_s = 1'b0;
        default:   score_pulse_nxt_s = 1'b0;
      endcase
    end
  end

  // Pipe, score and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe1_x_r     <= SPAWN_X;
      pipe1_gap_r   <= GAP_BASE;
      pipe1_valid_r <= 1'b0;
      pipe2_x_r     <= SPAWN_X;
      pipe2_gap_r   <= GAP_BASE;
      pipe2_valid_r <= 1'b0;
      score_r       <= 8'd0;
      score_pulse_r <= 1'b0;
    end else begin
      pipe1_x_r     <= pipe1_x_nxt_s;
      pipe1_gap_r   <= pipe1_gap_nxt_s;
      pipe1_valid_r <= pipe1_valid_nxt_s;
      pipe2_x_r     <= pipe2_x_nxt_s;
      pipe2_gap_r   <= pipe2_gap_nxt_s;
      pipe2_valid_r <= pipe2_valid_nxt_s;
      score_r       <= score_nxt_s;
      score_pulse_r <= score_pulse_nxt_s;
    end
  end

  assign bus.pipe1_x     = pipe1_x_r;
  assign bus.pipe1_gap   = pipe1_gap_r;
  assign bus.pipe1_valid = pipe1_valid_r;
  assign bus.pipe2_x     = pipe2_x_r;
  assign bus.pipe2_gap   = pipe2_gap_r;
  assign bus.pipe2_valid = pipe2_valid_r;
  assign bus.score       = score_r;
  assign bus.score_pulse = score_pulse_r;
  assign bus.state       = state_r;

endmodule
